// File: rtl/rr_mux_arbiter_if.sv
// Request/data/grant bundle between the requesting units and the shared
// output-channel arbiter.
interface rr_mux_arbiter_if #(
  parameter int W = 8
);
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic [W-1:0]   y;
  logic           y_valid;

  modport master (
    output req,
    output din,
    input  gnt,
    input  sel,
    input  y,
    input  y_valid
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output sel,
    output y,
    output y_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter that owns the shared mux select and registers the chosen beat.
// Optional forced rotation after MAX_HOLD grant cycles is enabled by `define MUX_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant outstanding, gnt = 0, waiting for any request
// GRANT | one requester owns the channel, sel points at it
module rr_mux_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input logic            clk,
  input logic            rst,
  rr_mux_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [1:0]   sel_q, sel_d;
  logic [1:0]   last_q, last_d;
  logic [W-1:0] y_q, y_d;
  logic         y_valid_q, y_valid_d;
  logic         force_rot;
  logic [2:0]   win;

  if (MAX_HOLD < 1) begin : g_max_hold_check
    $error("MAX_HOLD must be at least 1");
  end

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] hold_q, hold_d;

  assign force_rot = (state_q == GRANT) && (hold_q == HW'(MAX_HOLD - 1))
                     && (|(bus.req & ~gnt_q));

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  always_comb begin
    hold_d = hold_q;
    if (state_q == GRANT) begin
      if (gnt_d != gnt_q || hold_q == HW'(MAX_HOLD - 1)) hold_d = '0;
      else                                                 hold_d = hold_q + 1'b1;
    end else begin
      hold_d = '0;
    end
  end
`else
  assign force_rot = 1'b0;
`endif

  // The holder is masked out so a forced rotation treats it as if it had dropped.
  assign win = pick(bus.req & ~gnt_q, last_q + 2'd1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (win[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win[1:0];
          sel_d   = win[1:0];
          last_d  = win[1:0];
        end
      end
      GRANT: begin
        if (bus.req[sel_q] && !force_rot) begin
          y_d       = bus.din[sel_q*W +: W];
          y_valid_d = 1'b1;
        end else if (win[2]) begin
          gnt_d  = 4'b0001 << win[1:0];
          sel_d  = win[1:0];
          last_d = win[1:0];
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the shared `mux_2x1`-tree output channel. Four requesters compete for one `W`-bit output. The block grants one requester at a time and drives the mux `sel`. It registers the selected data onto `y` with a valid flag. It sits between the requesting units and the shared mux datapath and is the only block that drives `sel`.

## Interface
- `W`, default 8: data width per requester.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles. Used only when `MUX_ARB_TIMEOUT_EN` is defined.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request vector; `req[k]` high means requester k wants the channel.
- `din`  in  4*W  packed data; requester k occupies `din[k*W +: W]`.
- `gnt`  out  4  one-hot grant, registered; all zero when idle.
- `sel`  out  2  registered mux select, equal to the index of the granted requester; holds its last value when idle.
- `y`  out  W  registered output data.
- `y_valid`  out  1  `y` holds a beat from the granted requester.

## Operation
- Reset values: `gnt`=0000, `sel`=0, `y`=0, `y_valid`=0, FSM=IDLE.
  - The internal pointer `last`=3, so requester 0 has top priority after reset.
- FSM has two states: IDLE and GRANT.
- **IDLE**
  - If `req`==0, stay in IDLE with `gnt`=0.
  - Otherwise pick the first set `req[k]`, searching k = `last`+1, `last`+2, … mod 4.
  - Register `gnt`=one-hot(k), `sel`=k, `last`=k, and go to GRANT.
- **GRANT** (granted index g)
  - While `req[g]`=1: hold `gnt` and `sel`, and capture `y`<=`din[g]`, `y_valid`<=1 on every edge.
  - When `req[g]`=0:
    - Re-arbitrate in the same cycle among `req`, starting at g+1 mod 4.
    - If a winner exists, switch `gnt`/`sel` to it on that edge with no idle bubble, and set `last` to the winner.
    - If no winner exists, go to IDLE with `gnt`=0.
    - `y_valid`<=0 on that edge.
- `y` keeps its last value when `y_valid`=0. It is never cleared except by reset.
- Priority rotates only on a grant change. A requester that drops and reasserts waits behind every other pending requester.
- Simultaneous requests on the same cycle are resolved solely by rotation order from `last`.
- Pointer arithmetic is 2-bit and wraps naturally: 3+1 = 0.
- `rst` asserted mid-grant: on the next edge, all outputs return to their reset values and `last`=3, regardless of `req`.

## Timing
- Request to grant: `req[k]` sampled high at edge N (IDLE) gives `gnt[k]`/`sel` valid after edge N.
- Grant to data: the first `y_valid`=1 appears after edge N+1, provided `req[k]` is still high. Total latency from request to first data is 2 cycles.
- Handover: `req[g]` low at edge M with another request pending gives a new `gnt` after edge M. New data follows after edge M+1.
- Throughput: one beat per cycle while `req[g]` stays high.
- `gnt` is always one-hot or zero, and `sel` always matches the set `gnt` bit.

## Configuration
- Macro `MUX_ARB_TIMEOUT_EN`.
- **Defined**
  - A hold counter (width covering `MAX_HOLD`) clears on every new grant and increments each GRANT cycle.
  - When it reaches `MAX_HOLD`-1 and another `req` bit is set, the grant is forced to rotate on that edge exactly as if `req[g]` had dropped, and `y_valid`<=0.
  - If no other request is pending, the counter clears and the grant continues.
- **Not defined**
  - No counter is built.
  - A grant is held for as long as `req[g]` stays high, and `MAX_HOLD` is ignored.

## Test plan
- Reset check: `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0000, `sel`=0, `y`=0, `y_valid`=0. Release → `gnt`=0001 after the next edge, then `y`=`din[0]` with `y_valid`=1 one cycle later.
- Single requester: `req`=0100, `din[2]`=8'hA5 → `gnt`=0100 and `sel`=2 at cycle +1, `y`=A5 and `y_valid`=1 at cycle +2. Drop `req` → `gnt`=0000 and `y_valid`=0 on the next edge.
- Fairness: `req`=1111 held, each requester dropping its request after 1 beat → grant order 0,1,2,3,0 with no idle cycle between grants.
- Wrap-around: `last`=3, `req`=1001 → grant goes to 0. After 0 drops → grant goes to 3.
- Mid-grant reset: requester 1 granted and streaming 8'h3C, assert `rst` for one cycle → all outputs at reset values on the next edge. The next grant goes to 0 if `req[0]`=1.
- Timeout (only with `MUX_ARB_TIMEOUT_EN`, `MAX_HOLD`=4): `req`=0011 held constantly → `gnt` alternates 0001/0010 every 4 cycles. With `req`=0001 alone → `gnt` stays 0001.
